// File: rtl/lcd_wr_arbiter_pkg.sv
// Shared LCD definitions: FIFO word layout and write-arbiter state encoding.
// Used by the LCD init, printer and write-arbiter blocks.
package lcd_pkg;

    localparam int LCD_WORD_W = 17;
    localparam int LCD_DC_BIT = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lcd_wr_arbiter_if.sv
// Requester-side handshake and LCD write-FIFO port bundle for lcd_wr_arbiter.
// master = packet sources plus FIFO model; slave = the arbiter.
interface lcd_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 17
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wfull;
    logic               winc;
    logic [DW-1:0]      wdata;

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata
    );
endinterface

// File: rtl/lcd_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_idx,
// scanning cyclically, returned as index and one-hot.
module lcd_rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] last_idx,
    output logic [NREQ-1:0]         pick_oh,
    output logic [$clog2(NREQ)-1:0] pick_idx,
    output logic                    pick_any
);
    localparam int IW = $clog2(NREQ);

    int cand;

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        cand     = 0;
        // k runs 1..NREQ so the previous owner is considered last
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_idx) + k) % NREQ;
            if (!pick_any && eligible[cand]) begin
                pick_any = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    assign pick_oh = pick_any ? (NREQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/lcd_wr_arbiter.sv
// Packet-locked round-robin arbiter for the shared LCD write FIFO port.
// Optional idle-owner watchdog enabled by defining LCD_ARB_WDOG_EN.
//
// state     | meaning
// ARB_IDLE  | no owner; one-cycle arbitration among eligible requesters
// ARB_BURST | grant owner streams words into the FIFO until req_last
module lcd_wr_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int DW          = LCD_WORD_W,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_wr_arbiter_if.slave   bus,
    input  logic              init_lock,
    output logic [NREQ-1:0]   grant,
    output logic              wdog_err
);
    localparam int IW = $clog2(NREQ);

    arb_state_t      state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [IW-1:0]   own_idx, own_idx_nx;
    logic [IW-1:0]   last_idx, last_idx_nx;

    logic [NREQ-1:0] elig, pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            own_valid, own_last;
    logic [DW-1:0]   own_data;
    logic            xfer;
    logic            wdog_hit;

    assign elig = bus.req_valid & (init_lock ? NREQ'(1) : {NREQ{1'b1}});

    lcd_rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (elig),
        .last_idx (last_idx),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign own_valid = bus.req_valid[own_idx];
    assign own_last  = bus.req_last[own_idx];
    assign own_data  = bus.req_data[own_idx*DW +: DW];

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        own_idx_nx    = own_idx;
        last_idx_nx   = last_idx;
        bus.req_ready = '0;
        xfer          = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nx   = ARB_BURST;
                    grant_nx   = pick_oh;
                    own_idx_nx = pick_idx;
                end
            end
            ARB_BURST: begin
                if (!bus.wfull) bus.req_ready = grant;
                xfer = own_valid & ~bus.wfull;
                if ((xfer && own_last) || wdog_hit) begin
                    state_nx    = ARB_IDLE;
                    grant_nx    = '0;
                    last_idx_nx = own_idx;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    assign bus.winc  = xfer;
    assign bus.wdata = xfer ? own_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            own_idx  <= '0;
            last_idx <= IW'(NREQ - 1);
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            own_idx  <= own_idx_nx;
            last_idx <= last_idx_nx;
        end
    end

`ifdef LCD_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_cnt;
    logic          wdog_idle;

    // Only an owner that stalls with FIFO space available is counted as hung
    assign wdog_idle = (state == ARB_BURST) && !own_valid && !bus.wfull;
    assign wdog_hit  = wdog_idle && (wdog_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt <= CW'(WDOG_CYCLES - 1);
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= wdog_hit;
            if (state != ARB_BURST || xfer || wdog_hit)
                wdog_cnt <= CW'(WDOG_CYCLES - 1);
            else if (wdog_idle)
                wdog_cnt <= wdog_cnt - 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

endmodule
